// File: rtl/core_pkg.sv
// Shared definitions for the core's memory-port arbitration.
// Holds the arbiter state encoding and the fixed byte enables used
// for instruction fetches.
package core_pkg;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_INSTR = 2'd1,
    MA_DATA  = 2'd2
  } mem_arb_state_t;

  // Instruction fetches always read the full 16-bit word.
  localparam logic [1:0] MA_INSTR_BYTESEL = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one 16-bit memory port between prefetch and load/store.
// Latency: access seen in an idle cycle -> q_m_access the next cycle; master ack is combinational from q_m_ack.
// Backpressure: the grant is held until q_m_ack, then one mandatory idle cycle before the next grant.
//
// Ports:
//   clk, reset        core clock, asynchronous active-high reset
//   instr_m_*         prefetch master (read-only)
//   data_m_*          load/store master
//   q_m_*             shared external memory port
//   q_m_grant_data    high while the load/store master owns the port
module mem_arbiter
  import core_pkg::*;
#(
  parameter int max_data_streak = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in,
  output logic        q_m_grant_data
);

  localparam int STREAK_W = $clog2(max_data_streak + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(max_data_streak);

  mem_arb_state_t      state, state_next;
  logic [STREAK_W-1:0] streak, streak_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MA_IDLE;
      streak <= '0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  // Data wins by default; the streak counts data grants made while an
  // instruction request was waiting, and forces one instruction grant
  // once it reaches the limit.
  always_comb begin
    state_next  = state;
    streak_next = streak;
    case (state)
      MA_IDLE: begin
        if (data_m_access && instr_m_access) begin
          if (streak == STREAK_MAX) begin
            state_next  = MA_INSTR;
            streak_next = '0;
          end else begin
            state_next  = MA_DATA;
            streak_next = streak + STREAK_W'(1);
          end
        end else if (data_m_access) begin
          state_next  = MA_DATA;
          streak_next = '0;
        end else if (instr_m_access) begin
          state_next  = MA_INSTR;
          streak_next = '0;
        end
      end
      // Grant is held until the slave acks, even if the master drops access.
      MA_INSTR, MA_DATA: begin
        if (q_m_ack) state_next = MA_IDLE;
      end
      default: state_next = MA_IDLE;
    endcase
  end

  // q_m_access comes straight from the state register, so there is no
  // combinational path from either master's access to the port request.
  assign q_m_access     = (state != MA_IDLE);
  assign q_m_grant_data = (state == MA_DATA);

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    case (state)
      MA_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
      end
      MA_INSTR: begin
        q_m_addr    = instr_m_addr;
        q_m_bytesel = MA_INSTR_BYTESEL;
      end
      default: ;
    endcase
  end

  // A stray ack while idle matches neither grant and is dropped.
  assign instr_m_ack     = q_m_ack & (state == MA_INSTR);
  assign data_m_ack      = q_m_ack & (state == MA_DATA);
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for streak ordering and mid-transaction reset.
module tb_mem_arbiter;

  typedef struct packed {
    logic        ia;
    logic [18:0] iaddr;
    logic        da;
    logic [18:0] daddr;
    logic [15:0] dout;
    logic        wr;
    logic [1:0]  bs;
    logic        qack;
    logic [15:0] qdata;
  } in_t;

  typedef struct packed {
    logic        qacc;
    logic [18:0] qaddr;
    logic [15:0] qdout;
    logic        qwr;
    logic [1:0]  qbs;
    logic        iack;
    logic        dack;
    logic        gnt;
    logic [15:0] idat;
    logic [15:0] ddat;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam logic [18:0] IA = 19'h00abc;
  localparam logic [18:0] D1 = 19'h01234;
  localparam logic [18:0] D2 = 19'h7fff0;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] instr_m_addr = '0;
  logic        instr_m_access = 1'b0;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [18:0] data_m_addr = '0;
  logic [15:0] data_m_data_out = '0;
  logic        data_m_access = 1'b0;
  logic        data_m_wr_en = 1'b0;
  logic [1:0]  data_m_bytesel = '0;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;
  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_ack = 1'b0;
  logic [15:0] q_m_data_in = '0;
  logic        q_m_grant_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.max_data_streak(4)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack),
    .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel), .q_m_ack(q_m_ack),
    .q_m_data_in(q_m_data_in), .q_m_grant_data(q_m_grant_data)
  );

  task automatic apply(input in_t x);
    instr_m_access  = x.ia;
    instr_m_addr    = x.iaddr;
    data_m_access   = x.da;
    data_m_addr     = x.daddr;
    data_m_data_out = x.dout;
    data_m_wr_en    = x.wr;
    data_m_bytesel  = x.bs;
    q_m_ack         = x.qack;
    q_m_data_in     = x.qdata;
  endtask

  function automatic out_t sample();
    out_t s;
    s = '{q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel,
          instr_m_ack, data_m_ack, q_m_grant_data, instr_m_data_in, data_m_data_in};
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  vec_t vec [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_kind [10];
    int g, gap, cyc;
    out_t zero_o;

    zero_o = '0;
    //           ia  iaddr da  daddr dout      wr  bs     qack qdata
    vec[0]  = '{'{0, 0,  0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};
    vec[1]  = '{'{1, IA, 0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};
    vec[2]  = '{'{1, IA, 0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{1, IA, 16'h0,    0, 2'b11, 0, 0, 0, 16'h0,    16'h0}};
    vec[3]  = '{'{1, IA, 0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{1, IA, 16'h0,    0, 2'b11, 0, 0, 0, 16'h0,    16'h0}};
    vec[4]  = '{'{1, IA, 0,  0,  16'h0,    0, 2'b00, 1, 16'h5a5a}, '{1, IA, 16'h0,    0, 2'b11, 1, 0, 0, 16'h5a5a, 16'h5a5a}};
    vec[5]  = '{'{0, 0,  0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};
    vec[6]  = '{'{0, 0,  1,  D1, 16'hbeef, 1, 2'b01, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};
    vec[7]  = '{'{0, 0,  1,  D1, 16'hbeef, 1, 2'b01, 0, 16'h0},    '{1, D1, 16'hbeef, 1, 2'b01, 0, 0, 1, 16'h0,    16'h0}};
    vec[8]  = '{'{0, 0,  1,  D1, 16'hbeef, 1, 2'b01, 1, 16'h1111}, '{1, D1, 16'hbeef, 1, 2'b01, 0, 1, 1, 16'h1111, 16'h1111}};
    vec[9]  = '{'{0, 0,  0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};
    vec[10] = '{'{0, 0,  0,  0,  16'h0,    0, 2'b00, 1, 16'h2222}, '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h2222, 16'h2222}};
    vec[11] = '{'{0, 0,  0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};
    vec[12] = '{'{0, 0,  1,  D2, 16'h0,    0, 2'b11, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};
    vec[13] = '{'{0, 0,  0,  D2, 16'h0,    0, 2'b11, 0, 16'h0},    '{1, D2, 16'h0,    0, 2'b11, 0, 0, 1, 16'h0,    16'h0}};
    vec[14] = '{'{0, 0,  0,  D2, 16'h0,    0, 2'b11, 0, 16'h0},    '{1, D2, 16'h0,    0, 2'b11, 0, 0, 1, 16'h0,    16'h0}};
    vec[15] = '{'{0, 0,  0,  D2, 16'h0,    0, 2'b11, 1, 16'h3333}, '{1, D2, 16'h0,    0, 2'b11, 0, 1, 1, 16'h3333, 16'h3333}};
    vec[16] = '{'{0, 0,  0,  0,  16'h0,    0, 2'b00, 0, 16'h0},    '{0, 0,  16'h0,    0, 2'b00, 0, 0, 0, 16'h0,    16'h0}};

    // Reset state: all outputs zero, read data follows q_m_data_in.
    q_m_data_in = 16'hc3c3;
    #3;
    begin
      out_t e;
      e = zero_o;
      e.idat = 16'hc3c3;
      e.ddat = 16'hc3c3;
      check("reset_outputs", 128'(sample()), 128'(e));
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Per-cycle vector table.
    for (int k = 0; k < NV; k++) begin
      apply(vec[k].i);
      @(negedge clk);
      check($sformatf("vec%0d", k), 128'(sample()), 128'(vec[k].o));
      @(posedge clk); #1;
    end

    // Both masters request continuously; slave acks on the first grant cycle.
    for (int k = 0; k < 10; k++) exp_kind[k] = !(k == 4 || k == 9);
    apply('{1, IA, 1, D1, 16'h0, 0, 2'b11, 0, 16'h0});
    g = 0; gap = 0; cyc = 0;
    while (g < 10 && cyc < 200) begin
      @(negedge clk);
      if (q_m_access) begin
        check($sformatf("streak_grant%0d", g),
              128'({q_m_grant_data, data_m_ack, instr_m_ack}),
              128'({exp_kind[g], exp_kind[g], !exp_kind[g]}));
        check($sformatf("streak_gap%0d", g), 128'(gap), 128'(1));
        g++;
        gap = 0;
      end else begin
        gap++;
      end
      @(posedge clk); #1;
      q_m_ack = q_m_access;
      cyc++;
    end
    if (g < 10) check("streak_timeout", 128'(g), 128'(10));
    apply('0);

    // Reset in the middle of a data grant, then a late ack.
    apply('{0, 0, 1, D1, 16'hbeef, 1, 2'b01, 0, 16'h0});
    @(posedge clk); #1;
    check("rst_pre_grant", 128'({q_m_access, q_m_grant_data}), 128'(2'b11));
    #2 reset = 1'b1;
    #1 check("rst_immediate", 128'({q_m_access, q_m_addr, q_m_data_out, q_m_wr_en,
                                    q_m_bytesel, instr_m_ack, data_m_ack, q_m_grant_data}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    apply('{0, 0, 0, 0, 16'h0, 0, 2'b00, 1, 16'h4444});
    #1 check("rst_late_ack", 128'({q_m_access, instr_m_ack, data_m_ack}), 128'(0));
    @(posedge clk); #1;
    q_m_ack = 1'b0;
    check("rst_still_idle", 128'(q_m_access), 128'(0));
    apply('{1, IA, 0, 0, 16'h0, 0, 2'b00, 0, 16'h0});
    @(posedge clk); #1;
    check("post_rst_grant", 128'({q_m_access, q_m_grant_data, q_m_addr, q_m_bytesel}),
          128'({1'b1, 1'b0, IA, 2'b11}));
    q_m_ack = 1'b1;
    #1 check("post_rst_ack", 128'({instr_m_ack, data_m_ack}), 128'(2'b10));
    @(posedge clk); #1;
    apply('0);
    check("post_rst_idle", 128'(q_m_access), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
